// File: rtl/maskmul_share_gen.sv
// rtl/maskmul_share_gen.sv - masked share generator feeding the 2-bit masked multiplier
// Draws ma/mb/mq from a 16-bit LFSR and registers masked operands behind a valid/ready handshake.
module maskmul_share_gen #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  a,
    input  logic [1:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  am,
    output logic [1:0]  bm,
    output logic [1:0]  ma,
    output logic [1:0]  mb,
    output logic [1:0]  mq,
    output logic [15:0] txn_count
);

    logic [15:0] lfsr;
    logic [15:0] lfsr_next6;
    logic        accept;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Six steps per transaction so the six mask bits drawn each time are fresh.
    always_comb begin
        lfsr_next6 = lfsr;
        for (int i = 0; i < 6; i++) begin
            lfsr_next6 = lfsr_step(lfsr_next6);
        end
    end

    assign in_ready = !seed_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= SEED;
            out_valid <= 1'b0;
            am        <= 2'b00;
            bm        <= 2'b00;
            ma        <= 2'b00;
            mb        <= 2'b00;
            mq        <= 2'b00;
            txn_count <= 16'h0000;
        end else if (seed_load) begin
            // A zero seed would lock the LFSR, so fall back to the default seed.
            lfsr      <= (seed_in == 16'h0000) ? SEED : seed_in;
            out_valid <= 1'b0;
            txn_count <= 16'h0000;
        end else if (accept) begin
            am        <= a ^ lfsr[1:0];
            ma        <= lfsr[1:0];
            bm        <= b ^ lfsr[3:2];
            mb        <= lfsr[3:2];
            mq        <= lfsr[5:4];
            out_valid <= 1'b1;
            lfsr      <= lfsr_next6;
            txn_count <= txn_count + 16'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maskmul_share_gen.sv
// tb/tb_maskmul_share_gen.sv - randomized self-checking bench for maskmul_share_gen
// Cycle model plus an in-order scoreboard of accepted operands.
module tb_maskmul_share_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        reset;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  am;
    logic [1:0]  bm;
    logic [1:0]  ma;
    logic [1:0]  mb;
    logic [1:0]  mq;
    logic [15:0] txn_count;

    maskmul_share_gen #(.SEED(SEED)) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .am        (am),
        .bm        (bm),
        .ma        (ma),
        .mb        (mb),
        .mq        (mq),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_lfsr   = SEED;
    logic        m_valid  = 1'b0;
    logic [9:0]  m_bundle = '0;
    logic [15:0] m_txn    = '0;
    logic [3:0]  sb[$];
    bit          primed   = 0;
    bit          hist_on  = 0;
    int          n_accept = 0;
    int          hist_ma[4];
    int          hist_mb[4];
    int          hist_mq[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference LFSR: parity of the tapped bits shifted in at the bottom.
    function automatic logic [15:0] ref_advance(input logic [15:0] s, input int n);
        logic [15:0] t = s;
        for (int i = 0; i < n; i++) begin
            t = {t[14:0], ^(t & 16'hB400)};
        end
        return t;
    endfunction

    task automatic step();
        logic       rdy;
        logic       acc;
        logic [3:0] front;
        rdy = !seed_load && (!m_valid || out_ready);
        acc = 1'b0;
        if (primed) check_eq("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        if (reset) begin
            m_lfsr = SEED; m_valid = 1'b0; m_bundle = '0; m_txn = '0; sb.delete();
        end else if (seed_load) begin
            m_lfsr = (seed_in == 16'h0) ? SEED : seed_in; m_valid = 1'b0; m_txn = '0; sb.delete();
        end else begin
            if (m_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd0, 32'd1);
                end else begin
                    front = sb.pop_front();
                    check_eq("unmask", {28'b0, am ^ ma, bm ^ mb}, {28'b0, front});
                end
            end
            if (in_valid && rdy) begin
                m_bundle = {a ^ m_lfsr[1:0], b ^ m_lfsr[3:2], m_lfsr[1:0], m_lfsr[3:2], m_lfsr[5:4]};
                m_lfsr   = ref_advance(m_lfsr, 6);
                m_valid  = 1'b1;
                m_txn    = m_txn + 16'd1;
                sb.push_back({a, b});
                acc = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        primed = 1;
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check_eq("bundle", {22'b0, am, bm, ma, mb, mq}, {22'b0, m_bundle});
        check_eq("txn_count", {16'b0, txn_count}, {16'b0, m_txn});
        check_eq("lfsr", {16'b0, dut.lfsr}, {16'b0, m_lfsr});
        check_eq("lfsr_nonzero", {31'b0, dut.lfsr != 16'h0}, 32'd1);
        if (acc) begin
            n_accept++;
            if (hist_on) begin
                hist_ma[ma]++; hist_mb[mb]++; hist_mq[mq]++;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic sl, input logic [15:0] sd, input logic iv,
                         input logic [1:0] ia, input logic [1:0] ib, input logic ordy);
        reset = rst; seed_load = sl; seed_in = sd; in_valid = iv; a = ia; b = ib; out_ready = ordy;
        #1;
        step();
    endtask

    task automatic check_masks(input string tag, input logic [5:0] exp);
        check_eq(tag, {26'b0, ma, mb, mq}, {26'b0, exp});
    endtask

    initial begin
        int cycles;
        reset = 1'b1; seed_load = 1'b0; seed_in = '0; in_valid = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0);
        check_eq("reset_state", {15'b0, out_valid, am, bm, ma, mb, mq, 6'b0}, 32'd0);
        check_eq("reset_txn", {16'b0, txn_count}, 32'd0);

        // Single transaction after reset.
        drive(0, 0, 0, 1, 2'd3, 2'd2, 1);
        check_eq("first_bundle", {22'b0, am, bm, ma, mb, mq}, {22'b0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd2});
        check_eq("first_txn", {16'b0, txn_count}, 32'd1);
        check_eq("first_lfsr", {16'b0, dut.lfsr}, {16'b0, ref_advance(SEED, 6)});
        drive(0, 0, 0, 0, 0, 0, 1);

        // Backpressure.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 2'd1, 2'd1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 2'd2, 2'd3, 0);
            check_eq("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        end
        check_eq("bp_txn", {16'b0, txn_count}, 32'd1);
        drive(0, 0, 0, 1, 2'd2, 2'd3, 1);
        check_eq("bp_txn2", {16'b0, txn_count}, 32'd2);
        check_masks("bp_masks", {ref_advance(SEED, 6)[1:0], ref_advance(SEED, 6)[3:2], ref_advance(SEED, 6)[5:4]});

        // Streaming.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 2'(i), 2'(i + 1), 1);
            check_eq("stream_valid", {31'b0, out_valid}, 32'd1);
        end
        check_eq("stream_txn", {16'b0, txn_count}, 32'd8);

        // Zero seed load while a bundle is pending.
        reset = 0; seed_load = 1; seed_in = 16'h0; in_valid = 1; out_ready = 0;
        #1;
        check_eq("seed_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        check_eq("seed_valid", {31'b0, out_valid}, 32'd0);
        check_eq("seed_txn", {16'b0, txn_count}, 32'd0);
        drive(0, 0, 0, 1, 2'd3, 2'd2, 1);
        check_masks("zero_seed_masks", {2'd1, 2'd0, 2'd2});
        drive(0, 1, 16'h0001, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 2'd0, 2'd1, 1);
        check_masks("seed1_masks", {2'd1, 2'd0, 2'd0});

        // Reset during backpressure.
        drive(0, 0, 0, 1, 2'd2, 2'd1, 0);
        drive(0, 0, 0, 1, 2'd1, 2'd2, 0);
        drive(1, 0, 0, 1, 2'd1, 2'd2, 0);
        check_eq("midreset_state", {15'b0, out_valid, am, bm, ma, mb, mq, txn_count[5:0]}, 32'd0);
        drive(0, 0, 0, 1, 2'd3, 2'd2, 1);
        check_eq("midreset_first", {22'b0, am, bm, ma, mb, mq}, {22'b0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd2});

        // Random soak.
        for (int i = 0; i < 4; i++) begin
            hist_ma[i] = 0; hist_mb[i] = 0; hist_mq[i] = 0;
        end
        hist_on  = 1;
        n_accept = 0;
        cycles   = 0;
        while (n_accept < 1000 && cycles < 20000) begin
            drive(0, 0, 0, ($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 1'($urandom));
            cycles++;
        end
        check_eq("soak_accepts", {31'b0, n_accept >= 1000}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("hist_ma", {31'b0, hist_ma[i] >= 200 && hist_ma[i] <= 300}, 32'd1);
            check_eq("hist_mb", {31'b0, hist_mb[i] >= 200 && hist_mb[i] <= 300}, 32'd1);
            check_eq("hist_mq", {31'b0, hist_mq[i] >= 200 && hist_mq[i] <= 300}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
